// File: rtl/otter_regfile_mp.sv
// Multi-port integer register file for the pipelined OTTER core.
// Combinational read ports with write-to-read bypass, synchronous write
// ports (highest index wins on collision), optional hardwired zero register,
// and a per-register busy scoreboard used by decode for hazard detection.
// All state updates freeze while the cache stalls; reads and bypass do not.
module otter_regfile_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     stall,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*XLEN-1:0]   wr_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  output logic [DEPTH-1:0]         busy_vec
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [XLEN-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [NUM_WR-1:0] wr_ok;
  logic [NUM_RD-1:0] rd_byp;

  assign busy_vec = busy;

  // Qualify each write port: enabled and not targeting a hardwired r0
  always_comb begin
    wr_ok = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      wr_ok[j] = wr_en[j] && !(HAS_ZERO && (wr_addr[j*AW +: AW] == '0));
    end
  end

  // Next scoreboard: writebacks clear, then issue sets so a new producer wins
  always_comb begin
    busy_nxt = busy;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (wr_ok[j]) busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (iss_en && !(HAS_ZERO && (iss_addr == '0))) busy_nxt[iss_addr] = 1'b1;
    if (HAS_ZERO) busy_nxt[0] = 1'b0;
  end

  // Read ports: array value, overridden by the highest-index matching write
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_byp  = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
          rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
          rd_byp[i] = 1'b1;
        end
      end
      if (HAS_ZERO && (rd_addr[i*AW +: AW] == '0)) rd_data[i*XLEN +: XLEN] = '0;
      rd_busy[i] = busy[rd_addr[i*AW +: AW]] & ~rd_byp[i];
    end
  end

  // Register array: async clear, port-ordered writes so the last port wins
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) regs[AW'(k)] <= '0;
    end else if (!stall) begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j]) regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  // Scoreboard register: async clear, frozen during stall
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    busy <= '0;
    else if (!stall) busy <= busy_nxt;
  end

endmodule
